// File: rtl/btb_pkg.sv
// Shared BTB definitions: geometry, way record layout and PC field helpers.
// Used by the IF-stage lookup and the EX-stage writer.
package btb_pkg;
  localparam int NUM_SETS = 8;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 27;
  localparam int WAY_W    = 64;
  localparam int SET_W    = 128;

  // Field bit positions inside one 64-bit way
  localparam int VALID_BIT = 63;
  localparam int TAG_HI    = 62;
  localparam int TAG_LO    = 36;
  localparam int TARGET_HI = 35;
  localparam int TARGET_LO = 4;
  localparam int STATE_HI  = 3;
  localparam int STATE_LO  = 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       state;
    logic [1:0]       pad;
  } btb_way_t;

  function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
    return pc[INDEX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:INDEX_W+2];
  endfunction
endpackage

// File: rtl/btb_way_match.sv
// Single-way tag compare: reports hit, taken (state[1]) and the target,
// with the target forced to zero on a miss.
module btb_way_match
  import btb_pkg::*;
(
  input  btb_way_t         way,
  input  logic [TAG_W-1:0] tag,
  output logic             hit,
  output logic             taken,
  output logic [31:0]      target
);
  logic unused_pad;
  assign unused_pad = ^way.pad;

  always_comb begin
    hit    = way.valid && (way.tag == tag);
    taken  = hit && way.state[1];
    target = hit ? way.target : '0;
  end
endmodule

// File: rtl/btb_lookup.sv
// BTB storage (register array + LRU bits) with a registered IF-stage lookup
// and the EX-stage write port, including same-cycle write-to-lookup bypass.
module btb_lookup
  import btb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_valid,
  input  logic [31:0]         rd_pc,
  input  logic                stall,
  input  logic                flush,
  output logic                pred_valid,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  input  logic [INDEX_W-1:0]  upd_index,
  output logic [SET_W-1:0]    upd_set,
  output logic [NUM_SETS-1:0] lru_vec,
  input  logic                upd_we,
  input  logic [SET_W-1:0]    write_set,
  input  logic                next_lru_write
);
  logic [SET_W-1:0]    set_array_reg [NUM_SETS];
  logic [NUM_SETS-1:0] lru_reg;
  logic [NUM_SETS-1:0] lru_next;

  logic [INDEX_W-1:0] rd_index;
  logic [TAG_W-1:0]   rd_tag;
  logic [SET_W-1:0]   rd_set;
  btb_way_t           way1;
  btb_way_t           way2;
  logic               hit1, hit2, taken1, taken2;
  logic [31:0]        target1, target2;
  logic               lk_hit, lk_taken, touch;
  logic [31:0]        lk_target;
  logic [1:0]         unused_pc_lsb;

  assign unused_pc_lsb = rd_pc[1:0];
  assign rd_index      = pc_index(rd_pc);
  assign rd_tag        = pc_tag(rd_pc);
  // A write landing in the looked-up set this cycle must be visible to the lookup
  assign rd_set = (upd_we && upd_index == rd_index) ? write_set : set_array_reg[rd_index];
  assign way1   = btb_way_t'(rd_set[SET_W-1:WAY_W]);
  assign way2   = btb_way_t'(rd_set[WAY_W-1:0]);

  btb_way_match u_match_way1 (
    .way    (way1),
    .tag    (rd_tag),
    .hit    (hit1),
    .taken  (taken1),
    .target (target1)
  );

  btb_way_match u_match_way2 (
    .way    (way2),
    .tag    (rd_tag),
    .hit    (hit2),
    .taken  (taken2),
    .target (target2)
  );

  // Way1 has priority should both ways ever match
  always_comb begin
    lk_hit    = hit1 || hit2;
    lk_taken  = hit1 ? taken1 : taken2;
    lk_target = hit1 ? target1 : target2;
    touch     = rd_valid && !stall && !flush && lk_hit;
  end

  // LRU: an EX-stage commit to a set overrides a lookup touch of that set
  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_lru
    assign lru_next[gi] = (upd_we && upd_index == INDEX_W'(gi)) ? next_lru_write :
                          (touch && rd_index == INDEX_W'(gi))  ? !hit1 :
                          lru_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) set_array_reg[i] <= '0;
      lru_reg <= '0;
    end else begin
      lru_reg <= lru_next;
      if (upd_we) set_array_reg[upd_index] <= write_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (flush) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (!stall) begin
      pred_valid  <= rd_valid;
      pred_hit    <= rd_valid && lk_hit;
      pred_taken  <= rd_valid && lk_taken;
      pred_target <= rd_valid ? lk_target : '0;
    end
  end

  assign upd_set = set_array_reg[upd_index];
  assign lru_vec = lru_reg;
endmodule

// File: tb/tb_btb_lookup.sv
// Table-driven bench for btb_lookup with an expected-result queue, plus
// hand sequences for combinational set readback and asynchronous reset.
module tb_btb_lookup;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_valid;
  logic [31:0]  rd_pc;
  logic         stall;
  logic         flush;
  logic         pred_valid;
  logic         pred_hit;
  logic         pred_taken;
  logic [31:0]  pred_target;
  logic [2:0]   upd_index;
  logic [127:0] upd_set;
  logic [7:0]   lru_vec;
  logic         upd_we;
  logic [127:0] write_set;
  logic         next_lru_write;

  btb_lookup dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_valid       (rd_valid),
    .rd_pc          (rd_pc),
    .stall          (stall),
    .flush          (flush),
    .pred_valid     (pred_valid),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_index      (upd_index),
    .upd_set        (upd_set),
    .lru_vec        (lru_vec),
    .upd_we         (upd_we),
    .write_set      (write_set),
    .next_lru_write (next_lru_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rv;
    logic [31:0]  pc;
    logic         st;
    logic         fl;
    logic         we;
    logic [2:0]   ui;
    logic [127:0] ws;
    logic         nl;
    logic         e_valid;
    logic         e_hit;
    logic         e_taken;
    logic [31:0]  e_target;
    logic [7:0]   e_lru;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [7:0]  lru;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] mk_way(input logic v, input logic [26:0] tag,
                                         input logic [31:0] tgt, input logic [1:0] st);
    return {v, tag, tgt, st, 2'b00};
  endfunction

  task automatic add(input string nm, input logic rv, input logic [31:0] pc,
                     input logic st, input logic fl, input logic we, input logic [2:0] ui,
                     input logic [127:0] ws, input logic nl,
                     input logic ev, input logic eh, input logic et,
                     input logic [31:0] etg, input logic [7:0] el);
    vec_t v;
    v.name = nm; v.rv = rv; v.pc = pc; v.st = st; v.fl = fl; v.we = we;
    v.ui = ui; v.ws = ws; v.nl = nl; v.e_valid = ev; v.e_hit = eh;
    v.e_taken = et; v.e_target = etg; v.e_lru = el;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rd_valid = v.rv; rd_pc = v.pc; stall = v.st; flush = v.fl;
    upd_we = v.we; upd_index = v.ui; write_set = v.ws; next_lru_write = v.nl;
    sb.push_back('{valid: v.e_valid, hit: v.e_hit, taken: v.e_taken,
                   target: v.e_target, lru: v.e_lru});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("[%0t] %s: pred v=%0b h=%0b t=%0b tgt=%h lru=%h", $time, v.name,
             pred_valid, pred_hit, pred_taken, pred_target, lru_vec);
    check({v.name, " pred"}, {pred_valid, pred_hit, pred_taken, pred_target},
          {e.valid, e.hit, e.taken, e.target});
    check({v.name, " lru"}, lru_vec, e.lru);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w1a, w1b, w1c, w3a, w3b, w3c;
    vec_t post;
    w1a = mk_way(1'b1, 27'h80,  32'h0000_2000, 2'b11);
    w1b = mk_way(1'b1, 27'h80,  32'h0000_3000, 2'b11);
    w1c = mk_way(1'b1, 27'h80,  32'h0000_4000, 2'b01);
    w3a = mk_way(1'b1, 27'h80,  32'h0000_A000, 2'b10);
    w3b = mk_way(1'b1, 27'h100, 32'h0000_B000, 2'b11);
    w3c = mk_way(1'b1, 27'h180, 32'h0000_C000, 2'b01);

    //   name            rv  pc            st fl we ui ws                  nl  v  h  t  target         lru
    add("first_miss",    1, 32'h0000_1004, 0, 0, 0, 0, '0,                 0,  1, 0, 0, 32'h0,         8'h00);
    add("write_set1",    0, 32'h0,         0, 0, 1, 1, {w1a, 64'h0},       1,  0, 0, 0, 32'h0,         8'h02);
    add("hit_way1",      1, 32'h0000_1004, 0, 0, 0, 0, '0,                 0,  1, 1, 1, 32'h0000_2000, 8'h00);
    add("bypass_hit",    1, 32'h0000_1004, 0, 0, 1, 1, {w1b, 64'h0},       1,  1, 1, 1, 32'h0000_3000, 8'h02);
    add("write_nt",      0, 32'h0,         0, 0, 1, 1, {w1c, 64'h0},       1,  0, 0, 0, 32'h0,         8'h02);
    add("hit_not_taken", 1, 32'h0000_1004, 0, 0, 0, 0, '0,                 0,  1, 1, 0, 32'h0000_4000, 8'h00);
    add("stall_0",       1, 32'h0000_2000, 1, 0, 0, 0, '0,                 0,  1, 1, 0, 32'h0000_4000, 8'h00);
    add("stall_1",       0, 32'h0000_5008, 1, 0, 0, 0, '0,                 0,  1, 1, 0, 32'h0000_4000, 8'h00);
    add("stall_2",       1, 32'h0000_100C, 1, 0, 0, 0, '0,                 0,  1, 1, 0, 32'h0000_4000, 8'h00);
    add("flush_stall",   1, 32'h0000_1004, 1, 1, 0, 0, '0,                 0,  0, 0, 0, 32'h0,         8'h00);
    add("fill_set3",     0, 32'h0,         0, 0, 1, 3, {w3a, w3b},         1,  0, 0, 0, 32'h0,         8'h08);
    add("set3_way1",     1, 32'h0000_100C, 0, 0, 0, 0, '0,                 0,  1, 1, 1, 32'h0000_A000, 8'h00);
    add("set3_way2",     1, 32'h0000_200C, 0, 0, 0, 0, '0,                 0,  1, 1, 1, 32'h0000_B000, 8'h08);
    add("insert_way1",   1, 32'h0000_1004, 0, 0, 1, 3, {w3c, w3b},         0,  1, 1, 0, 32'h0000_4000, 8'h00);
    add("evicted_miss",  1, 32'h0000_100C, 0, 0, 0, 0, '0,                 0,  1, 0, 0, 32'h0,         8'h00);
    add("new_tag_hit",   1, 32'h0000_300C, 0, 0, 0, 0, '0,                 0,  1, 1, 0, 32'h0000_C000, 8'h00);
    add("touch_and_wr",  1, 32'h0000_200C, 0, 0, 1, 5, '0,                 1,  1, 1, 1, 32'h0000_B000, 8'h28);
    add("idle",          0, 32'h0000_200C, 0, 0, 0, 0, '0,                 0,  0, 0, 0, 32'h0,         8'h28);
    add("tag_mismatch",  1, 32'h0000_2004, 0, 0, 0, 0, '0,                 0,  1, 0, 0, 32'h0,         8'h28);
    add("pre_reset_hit", 1, 32'h0000_200C, 0, 0, 0, 0, '0,                 0,  1, 1, 1, 32'h0000_B000, 8'h28);

    rst_n = 1'b0; rd_valid = 1'b0; rd_pc = '0; stall = 1'b0; flush = 1'b0;
    upd_we = 1'b0; upd_index = '0; write_set = '0; next_lru_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pred", {pred_valid, pred_hit, pred_taken, pred_target}, '0);
    check("reset lru", lru_vec, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Combinational set readback reflects committed contents only
    @(negedge clk);
    rd_valid = 1'b0; upd_we = 1'b0; upd_index = 3'd3;
    #1;
    $display("[%0t] readback set3: %h", $time, upd_set);
    check("upd_set idx3", upd_set, {w3c, w3b});
    upd_index = 3'd1;
    #1;
    $display("[%0t] readback set1: %h", $time, upd_set);
    check("upd_set idx1", upd_set, {w1c, 64'h0});

    // Asynchronous reset mid-cycle after a hit is held in the prediction registers
    apply(vecs[vecs.size()-1]);
    #2;
    rst_n = 1'b0;
    upd_index = 3'd3;
    #1;
    $display("[%0t] async reset: pred v=%0b h=%0b tgt=%h lru=%h", $time,
             pred_valid, pred_hit, pred_target, lru_vec);
    check("async pred", {pred_valid, pred_hit, pred_taken, pred_target}, '0);
    check("async lru", lru_vec, '0);
    check("async set3", upd_set, '0);
    @(negedge clk);
    rst_n = 1'b1;
    post.name = "post_reset_miss"; post.rv = 1'b1; post.pc = 32'h0000_200C;
    post.st = 1'b0; post.fl = 1'b0; post.we = 1'b0; post.ui = 3'd0; post.ws = '0;
    post.nl = 1'b0; post.e_valid = 1'b1; post.e_hit = 1'b0; post.e_taken = 1'b0;
    post.e_target = '0; post.e_lru = 8'h00;
    apply(post);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
